ram_1r1w_sched: RTL and testbench
=================================

Name: ram_1r1w_sched

Overview:
- Shares one 1-read/1-write RAM between NREQ write requesters and NREQ read requesters.
- Write port and read port are arbitrated independently with round-robin.
- Read data is routed back to the granted requester after the RAM read latency.
- Sits between client engines and the RAM instance; the RAM runs with wr_clk = rd_clk = clk.

Parameters:
- NREQ, 4, number of requesters per port (2..8).
- DW, 8, data width.
- AW, 10, address width.
- LATENCY, 1, RAM read latency; only 0 or 1 is legal.

Ports:
- clk  in  1  single clock for block and RAM.
- rst  in  1  synchronous, active-high reset.
- wr_req  in  NREQ  per-requester write request.
- wr_addr  in  NREQ*AW  packed write addresses; requester i at [i*AW +: AW].
- wr_data  in  NREQ*DW  packed write data.
- wr_gnt  out  NREQ  one-hot write grant.
- rd_req  in  NREQ  per-requester read request.
- rd_addr  in  NREQ*AW  packed read addresses.
- rd_gnt  out  NREQ  one-hot read grant.
- rd_vld  out  NREQ  one-hot read-data-valid.
- rd_data  out  DW  read data, broadcast to all requesters and qualified by rd_vld.
- ram_wr  out  1  RAM write enable.
- ram_waddr  out  AW  RAM write address.
- ram_wdata  out  DW  RAM write data.
- ram_rd  out  1  RAM read enable.
- ram_raddr  out  AW  RAM read address.
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Handshake
  - A requester holds req, addr and data stable until it sees gnt high in the same cycle.
  - The transfer completes in that cycle. Dropping req before gnt is legal; nothing is issued.
- Grants
  - Grants are combinational from req and the registered priority pointer, at most one per port per cycle.
  - Arbitration is round-robin. Search starts at pointer p (wr_ptr or rd_ptr) and goes p, p+1, ..., wrapping mod NREQ.
  - On a grant to index k, the pointer becomes (k+1) mod NREQ at the next edge. With no grant, the pointer holds.
  - NREQ not a power of two: wrap at NREQ-1 → 0 explicitly.
- RAM drive
  - ram_wr = |wr_gnt. ram_waddr/ram_wdata are muxed from the granted index, and are 0 when no grant.
  - Read side is the same: ram_rd = |rd_gnt, ram_raddr muxed from the granted index.
- Read return
  - LATENCY=1: granted index is registered. rd_vld is one-hot on that index one cycle after rd_gnt, with rd_data = ram_rdata.
  - LATENCY=0: rd_vld = rd_gnt in the same cycle, and rd_data = ram_rdata combinational.
- Back-to-back: sustained 1 write + 1 read per cycle, no bubbles.
- Write/read collision (same address, same cycle, no bypass feature)
  - LATENCY=1: read returns the old contents (read-before-write).
  - LATENCY=0: read returns the old contents; the new value is visible the following cycle.
- Reset
  - wr_ptr = rd_ptr = 0.
  - rd_vld = 0, and the in-flight return register is cleared: a read granted in the reset cycle is dropped, with no rd_vld.
  - rd_data follows ram_rdata; don't-care when rd_vld = 0.
  - Grants are forced to 0 while rst = 1.
- LATENCY other than 0/1: elaboration error via generate-time check.

Optional Feature:
- Macro: RAM_SCHED_WR_BYPASS_EN.
- Enabled: when a read and a write are granted in the same cycle to the same address, the returned rd_data is the write data.
  - LATENCY=1: wdata and a hit flag are registered, and the mux is applied in the return cycle.
  - LATENCY=0: the mux is combinational.
- Disabled: collision returns old data as described under Behaviour. No extra registers.

Decomposition:
- Package ram_sched_pkg holds:
  - clog2-based index-width function.
  - LATENCY legality constants.
  - Packed-slice helper macros for [i*W +: W].
- Sub-module rr_arbiter (NREQ; req, gnt, ptr register with clk/rst) is instantiated once for the write port and once for the read port.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, then all req=0 → all gnt=0, ram_wr=ram_rd=0, rd_vld=0, pointers 0.
- Round-robin: wr_req=4'b1111 held for 8 cycles → wr_gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Skip/fairness: rd_req=4'b1010 held, pointer at 0 → rd_gnt 0010, 1000, 0010; a late rd_req[0] is granted within ≤4 cycles.
- Write then read: req1 writes 0xA5 to addr 0x3F; next cycle req2 reads 0x3F. With LATENCY=1, rd_vld=0100 and rd_data=0xA5 one cycle after rd_gnt.
- Collision: addr 0x10 holds 0x11; same cycle, write 0x22 and read 0x10. Without the macro → 0x11; with RAM_SCHED_WR_BYPASS_EN → 0x22.
- Reset mid-read: rd_gnt asserted, rst=1 on the next edge → no rd_vld; pointers back to 0; first post-reset grant goes to the lowest requesting index.

Source files
------------

// File: rtl/ram_sched_pkg.sv
// Shared helpers for the 1R1W RAM scheduler: index width, legal parameter ranges
// and packed-slice macros.
`ifndef RAM_SCHED_PKG_SV
`define RAM_SCHED_PKG_SV

// Slice requester i out of a flat vector of W-bit fields.
`define RS_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package ram_sched_pkg;

    localparam int RS_LAT_MIN  = 0;
    localparam int RS_LAT_MAX  = 1;
    localparam int RS_NREQ_MIN = 2;
    localparam int RS_NREQ_MAX = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered
// pointer, which moves to one past the winner after each grant.
module rr_arbiter
    import ram_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_gnt_idx,
    output logic            o_gnt_any
);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int off = 0; off < NREQ; off++) begin
            // Explicit wrap so non-power-of-two NREQ never visits unused indices.
            w_sum = {1'b0, r_ptr} + (IW+1)'(off);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end
            w_idx = w_sum[IW-1:0];
            if (!o_gnt_any && i_req[w_idx]) begin
                o_gnt_any     = 1'b1;
                o_gnt[w_idx]  = 1'b1;
                o_gnt_idx     = w_idx;
            end
        end
        if (rst) begin
            o_gnt     = '0;
            o_gnt_idx = '0;
            o_gnt_any = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_gnt_any) begin
            r_ptr <= (o_gnt_idx == IW'(NREQ-1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ram_1r1w_sched.sv
// Shares one 1R1W RAM between NREQ writers and NREQ readers, routing read data
// back to the granted reader. Optional same-address write bypass: RAM_SCHED_WR_BYPASS_EN.
module ram_1r1w_sched
    import ram_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int AW      = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   wr_req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]   wr_gnt,
    input  logic [NREQ-1:0]   rd_req,
    input  logic [NREQ*AW-1:0] rd_addr,
    output logic [NREQ-1:0]   rd_gnt,
    output logic [NREQ-1:0]   rd_vld,
    output logic [DW-1:0]     rd_data,
    output logic              ram_wr,
    output logic [AW-1:0]     ram_waddr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_rd,
    output logic [AW-1:0]     ram_raddr,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int IW = idx_w(NREQ);

    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic          w_wr_any;
    logic          w_rd_any;

    generate
        if (LATENCY < RS_LAT_MIN || LATENCY > RS_LAT_MAX) begin : g_bad_latency
            $error("ram_1r1w_sched: LATENCY must be 0 or 1");
        end
        if (NREQ < RS_NREQ_MIN || NREQ > RS_NREQ_MAX) begin : g_bad_nreq
            $error("ram_1r1w_sched: NREQ must be 2..8");
        end
    endgenerate

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (wr_req),
        .o_gnt     (wr_gnt),
        .o_gnt_idx (w_wr_idx),
        .o_gnt_any (w_wr_any)
    );

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (rd_req),
        .o_gnt     (rd_gnt),
        .o_gnt_idx (w_rd_idx),
        .o_gnt_any (w_rd_any)
    );

    assign ram_wr    = w_wr_any;
    assign ram_waddr = w_wr_any ? `RS_SLICE(wr_addr, w_wr_idx, AW) : '0;
    assign ram_wdata = w_wr_any ? `RS_SLICE(wr_data, w_wr_idx, DW) : '0;
    assign ram_rd    = w_rd_any;
    assign ram_raddr = w_rd_any ? `RS_SLICE(rd_addr, w_rd_idx, AW) : '0;

`ifdef RAM_SCHED_WR_BYPASS_EN
    logic w_byp_hit;
    assign w_byp_hit = w_wr_any && w_rd_any && (ram_waddr == ram_raddr);
`endif

    generate
        if (LATENCY == 1) begin : g_lat1
            logic          r_rd_vld;
            logic [IW-1:0] r_rd_idx;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_vld <= 1'b0;
                    r_rd_idx <= '0;
                end else begin
                    r_rd_vld <= w_rd_any;
                    r_rd_idx <= w_rd_idx;
                end
            end

            for (genvar gi = 0; gi < NREQ; gi++) begin : g_vld
                assign rd_vld[gi] = r_rd_vld && (r_rd_idx == IW'(gi));
            end

`ifdef RAM_SCHED_WR_BYPASS_EN
            logic          r_byp_hit;
            logic [DW-1:0] r_byp_data;

            // The RAM returns the old word in the return cycle; substitute the captured write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_byp_hit  <= 1'b0;
                    r_byp_data <= '0;
                end else begin
                    r_byp_hit  <= w_byp_hit;
                    r_byp_data <= ram_wdata;
                end
            end
            assign rd_data = r_byp_hit ? r_byp_data : ram_rdata;
`else
            assign rd_data = ram_rdata;
`endif
        end else begin : g_lat0
            assign rd_vld = rd_gnt;
`ifdef RAM_SCHED_WR_BYPASS_EN
            assign rd_data = w_byp_hit ? ram_wdata : ram_rdata;
`else
            assign rd_data = ram_rdata;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ram_1r1w_sched.sv
// Directed bench for ram_1r1w_sched (NREQ=4, DW=8, AW=10, LATENCY=1) with a
// read-before-write RAM model attached to the RAM port.
module tb_ram_1r1w_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 10;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    wr_req;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    wr_gnt;
    logic [NREQ-1:0]    rd_req;
    logic [NREQ*AW-1:0] rd_addr;
    logic [NREQ-1:0]    rd_gnt;
    logic [NREQ-1:0]    rd_vld;
    logic [DW-1:0]      rd_data;
    logic               ram_wr;
    logic [AW-1:0]      ram_waddr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_rd;
    logic [AW-1:0]      ram_raddr;
    logic [DW-1:0]      ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks;
    int n_fail;
    int exp_rd [5] = '{2, 8, 2, 8, 1};
    logic [31:0] exp_coll;

    ram_1r1w_sched #(.NREQ(NREQ), .DW(DW), .AW(AW), .LATENCY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .ram_wr    (ram_wr),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_rd    (ram_rd),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read-before-write RAM.
    always @(posedge clk) begin
        if (ram_rd) ram_rdata <= mem[ram_raddr];
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input logic [AW-1:0] a);
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ram_rdata = '0;
        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
        rst     = 1'b1;
        wr_req  = '0;
        rd_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
`ifdef RAM_SCHED_WR_BYPASS_EN
        exp_coll = 32'h22;
`else
        exp_coll = 32'h11;
`endif

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_wr_gnt", 32'(wr_gnt), 32'h0);
        chk("idle_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("idle_ram_wr", 32'(ram_wr), 32'h0);
        chk("idle_ram_rd", 32'(ram_rd), 32'h0);
        chk("idle_rd_vld", 32'(rd_vld), 32'h0);
        step();

        // Round-robin over all four writers
        for (int i = 0; i < NREQ; i++) set_wr(i, AW'(10'h100 + i), DW'(8'h30 + i));
        wr_req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] e;
            e = 4'(1 << (c % 4));
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", c), 32'(wr_gnt), 32'(e));
            chk($sformatf("rr_waddr%0d", c), 32'(ram_waddr), 32'h100 + 32'(c % 4));
            chk($sformatf("rr_wdata%0d", c), 32'(ram_wdata), 32'h30 + 32'(c % 4));
            step();
        end
        wr_req = '0;

        // Skip idle readers, then a late reader 0 joins
        rd_req = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) rd_req = 4'b1011;
            @(negedge clk);
            chk($sformatf("skip_gnt%0d", c), 32'(rd_gnt), 32'(exp_rd[c]));
            chk($sformatf("skip_vld%0d", c), 32'(rd_vld), (c == 0) ? 32'h0 : 32'(exp_rd[c-1]));
            step();
        end
        rd_req = '0;
        @(negedge clk);
        chk("skip_vld_tail", 32'(rd_vld), 32'h1);
        step();

        // Write 0xA5 to 0x3F from requester 1, then read it back from requester 2
        set_wr(1, 10'h03F, 8'hA5);
        wr_req = 4'b0010;
        @(negedge clk);
        chk("wr_gnt_1", 32'(wr_gnt), 32'h2);
        chk("wr_waddr", 32'(ram_waddr), 32'h3F);
        chk("wr_wdata", 32'(ram_wdata), 32'hA5);
        step();
        wr_req = '0;
        set_rd(2, 10'h03F);
        rd_req = 4'b0100;
        @(negedge clk);
        chk("rd_gnt_2", 32'(rd_gnt), 32'h4);
        chk("rd_raddr", 32'(ram_raddr), 32'h3F);
        chk("rd_vld_pre", 32'(rd_vld), 32'h0);
        step();
        rd_req = '0;
        @(negedge clk);
        chk("rd_vld_2", 32'(rd_vld), 32'h4);
        chk("rd_data_a5", 32'(rd_data), 32'hA5);
        step();

        // Collision: 0x10 holds 0x11, then write 0x22 and read 0x10 together
        set_wr(0, 10'h010, 8'h11);
        wr_req = 4'b0001;
        @(negedge clk);
        chk("coll_pre_gnt", 32'(wr_gnt), 32'h1);
        step();
        set_wr(3, 10'h010, 8'h22);
        set_rd(0, 10'h010);
        wr_req = 4'b1000;
        rd_req = 4'b0001;
        @(negedge clk);
        chk("coll_wr_gnt", 32'(wr_gnt), 32'h8);
        chk("coll_rd_gnt", 32'(rd_gnt), 32'h1);
        step();
        wr_req = '0;
        rd_req = '0;
        @(negedge clk);
        chk("coll_vld", 32'(rd_vld), 32'h1);
        chk("coll_data", 32'(rd_data), exp_coll);
        step();
        rd_req = 4'b0001;
        @(negedge clk);
        chk("after_coll_gnt", 32'(rd_gnt), 32'h1);
        step();
        rd_req = '0;
        @(negedge clk);
        chk("after_coll_vld", 32'(rd_vld), 32'h1);
        chk("after_coll_data", 32'(rd_data), 32'h22);
        step();

        // Reset while a read is granted
        set_rd(2, 10'h03F);
        rd_req = 4'b0100;
        wr_req = 4'b0010;
        @(negedge clk);
        chk("mid_rd_gnt", 32'(rd_gnt), 32'h4);
        chk("mid_wr_gnt", 32'(wr_gnt), 32'h2);
        rst = 1'b1;
        #1;
        chk("rst_rd_gnt", 32'(rd_gnt), 32'h0);
        chk("rst_wr_gnt", 32'(wr_gnt), 32'h0);
        chk("rst_ram_rd", 32'(ram_rd), 32'h0);
        step();
        rst    = 1'b0;
        rd_req = 4'b1001;
        wr_req = 4'b0110;
        @(negedge clk);
        chk("post_rst_vld", 32'(rd_vld), 32'h0);
        chk("post_rst_rd_gnt", 32'(rd_gnt), 32'h1);
        chk("post_rst_wr_gnt", 32'(wr_gnt), 32'h2);
        step();
        rd_req = '0;
        wr_req = '0;
        @(negedge clk);
        chk("post_rst_vld2", 32'(rd_vld), 32'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
